// File: rtl/window_gen_3x3.sv
// Streaming 3x3 sliding-window generator.
// Pixels arrive one per accepted cycle in row-major raster order. Two
// IMG_WIDTH-deep line buffers supply the pixels one and two rows above the
// incoming pixel, and these feed the right-hand column of a 3x3 window
// register. A window is flagged valid only when it lies wholly inside the
// frame (row >= 2 and col >= 2 of the pixel just accepted).
module window_gen_3x3 #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_WIDTH-1:0]           Data_In,
    input  logic                            Valid_In,
    output logic [9*DATA_WIDTH-1:0]         Window_Out,
    output logic                            Valid_Out,
    output logic                            Frame_Done,
    output logic [$clog2(IMG_WIDTH)-1:0]    Col_Idx,
    output logic [$clog2(IMG_HEIGHT)-1:0]   Row_Idx
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic [DATA_WIDTH-1:0] r_lb1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] r_lb2 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] r_win [9];
    logic                  r_valid;
    logic                  r_frame_done;

    logic w_col_last;
    logic w_row_last;
    logic w_in_window;

    // Position decode of the pixel being accepted (pre-increment counters)
    always_comb begin
        w_col_last  = (r_col == COL_LAST);
        w_row_last  = (r_row == ROW_LAST);
        w_in_window = (r_row >= RW'(2)) && (r_col >= CW'(2));
    end

    // Raster position counters; wrap at end of row and end of frame
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (Valid_In) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Line buffers: LB1 tail is one row above, LB2 tail is two rows above
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < IMG_WIDTH; i++) begin
                r_lb1[i] <= '0;
                r_lb2[i] <= '0;
            end
        end else if (Valid_In) begin
            r_lb1[0] <= Data_In;
            r_lb2[0] <= r_lb1[IMG_WIDTH-1];
            for (int i = 1; i < IMG_WIDTH; i++) begin
                r_lb1[i] <= r_lb1[i-1];
                r_lb2[i] <= r_lb2[i-1];
            end
        end
    end

    // Window register: shift columns left, load new right column from buffers
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= '0;
            end
        end else if (Valid_In) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r*3]     <= r_win[r*3 + 1];
                r_win[r*3 + 1] <= r_win[r*3 + 2];
            end
            r_win[2] <= r_lb2[IMG_WIDTH-1];
            r_win[5] <= r_lb1[IMG_WIDTH-1];
            r_win[8] <= Data_In;
        end
    end

    // Valid and end-of-frame flags; idle cycles clear both
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid      <= Valid_In && w_in_window;
            r_frame_done <= Valid_In && w_col_last && w_row_last;
        end
    end

    // Pack window elements, k = r*3 + c, element 0 at the LSBs
    always_comb begin
        Window_Out = '0;
        for (int k = 0; k < 9; k++) begin
            Window_Out[k*DATA_WIDTH +: DATA_WIDTH] = r_win[k];
        end
    end

    assign Valid_Out  = r_valid;
    assign Frame_Done = r_frame_done;
    assign Col_Idx    = r_col;
    assign Row_Idx    = r_row;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3 with a 5x4 frame of 8-bit pixels,
// pixel value = base + row*16 + col.
module tb_window_gen_3x3;

    localparam int DW = 8;
    localparam int IW = 5;
    localparam int IH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [DW-1:0]   Data_In;
    logic            Valid_In;
    logic [9*DW-1:0] Window_Out;
    logic            Valid_Out;
    logic            Frame_Done;
    logic [2:0]      Col_Idx;
    logic [1:0]      Row_Idx;

    int n_checks = 0;
    int n_errors = 0;
    int n_vo     = 0;
    int n_fd     = 0;
    int exp_col  = 0;
    int exp_row  = 0;
    bit last_valid = 1'b0;
    logic [9*DW-1:0] last_win = '0;

    window_gen_3x3 #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (IW),
        .IMG_HEIGHT (IH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Data_In    (Data_In),
        .Valid_In   (Valid_In),
        .Window_Out (Window_Out),
        .Valid_Out  (Valid_Out),
        .Frame_Done (Frame_Done),
        .Col_Idx    (Col_Idx),
        .Row_Idx    (Row_Idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [9*DW-1:0] win_exp(input int r, input int c, input int base);
        logic [9*DW-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(i*3+j)*DW +: DW] = DW'(base + (r-2+i)*16 + (c-2+j));
        return w;
    endfunction

    task automatic tally();
        if (Valid_Out === 1'b1) n_vo++;
        if (Frame_Done === 1'b1) n_fd++;
    endtask

    task automatic step_pixel(input int r, input int c, input int base);
        bit ev;
        Data_In  = DW'(base + r*16 + c);
        Valid_In = 1'b1;
        @(posedge clk);
        #1;
        tally();
        ev = (r >= 2) && (c >= 2);
        chk("valid_out", {71'd0, Valid_Out}, {71'd0, ev});
        chk("frame_done", {71'd0, Frame_Done}, {71'd0, (r == IH-1) && (c == IW-1)});
        if (ev) chk($sformatf("window_r%0d_c%0d", r, c), Window_Out, win_exp(r, c, base));
        if (c == IW-1) begin
            exp_col = 0;
            exp_row = (r == IH-1) ? 0 : r + 1;
        end else begin
            exp_col = c + 1;
        end
        chk("col_idx", {69'd0, Col_Idx}, 72'(exp_col));
        chk("row_idx", {70'd0, Row_Idx}, 72'(exp_row));
        last_valid = ev;
        last_win   = win_exp(r, c, base);
    endtask

    task automatic step_idle();
        Valid_In = 1'b0;
        Data_In  = DW'($urandom_range(0, 255));
        @(posedge clk);
        #1;
        tally();
        chk("idle_valid_out", {71'd0, Valid_Out}, 72'd0);
        chk("idle_frame_done", {71'd0, Frame_Done}, 72'd0);
        chk("idle_col_idx", {69'd0, Col_Idx}, 72'(exp_col));
        chk("idle_row_idx", {70'd0, Row_Idx}, 72'(exp_row));
        if (last_valid) chk("idle_window_hold", Window_Out, last_win);
    endtask

    task automatic frame(input int base, input int max_gap);
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) begin
                step_pixel(r, c, base);
                if (max_gap > 0) repeat ($urandom_range(0, max_gap)) step_idle();
            end
    endtask

    task automatic reset_cycle(input logic vin, input string tag);
        reset    = 1'b0;
        Valid_In = vin;
        Data_In  = 8'hA5;
        @(posedge clk);
        #1;
        tally();
        chk({tag, "_valid_out"}, {71'd0, Valid_Out}, 72'd0);
        chk({tag, "_frame_done"}, {71'd0, Frame_Done}, 72'd0);
        chk({tag, "_window"}, Window_Out, 72'd0);
        chk({tag, "_col_idx"}, {69'd0, Col_Idx}, 72'd0);
        chk({tag, "_row_idx"}, {70'd0, Row_Idx}, 72'd0);
        exp_col    = 0;
        exp_row    = 0;
        last_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        Valid_In = 1'b0;
        Data_In  = '0;
        @(posedge clk);
        reset_cycle(1'b0, "por");
        reset = 1'b1;

        // 1+2: gapless frame, first/last window, frame_done
        n_vo = 0; n_fd = 0;
        frame(0, 0);
        chk("gapless_window_count", 72'(n_vo), 72'd6);
        chk("gapless_frame_done_count", 72'(n_fd), 72'd1);

        // 3: random gaps of 0..3 idle cycles
        n_vo = 0; n_fd = 0;
        frame(0, 3);
        step_idle();
        chk("gaps_window_count", 72'(n_vo), 72'd6);
        chk("gaps_frame_done_count", 72'(n_fd), 72'd1);

        // 4: back-to-back frames, second frame offset by 0x40
        n_vo = 0; n_fd = 0;
        frame(0, 0);
        frame(8'h40, 0);
        chk("b2b_window_count", 72'(n_vo), 72'd12);
        chk("b2b_frame_done_count", 72'(n_fd), 72'd2);

        // 5: reset after pixel (2,3), then a fresh gapless frame
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < IW; c++)
                if (r < 2 || c <= 3) step_pixel(r, c, 0);
        reset_cycle(1'b0, "midframe_rst");
        reset = 1'b1;
        n_vo = 0; n_fd = 0;
        frame(0, 0);
        chk("post_rst_window_count", 72'(n_vo), 72'd6);
        chk("post_rst_frame_done_count", 72'(n_fd), 72'd1);

        // 6: reset held with Valid_In=1 for 5 cycles
        for (int r = 0; r < 3; r++) step_pixel(0, r, 0);
        n_vo = 0;
        repeat (5) reset_cycle(1'b1, "rst_priority");
        reset = 1'b1;
        chk("rst_priority_no_valid", 72'(n_vo), 72'd0);
        n_vo = 0; n_fd = 0;
        frame(8'h40, 1);
        step_idle();
        chk("final_window_count", 72'(n_vo), 72'd6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
